// File: rtl/wb_pkg.sv
// Shared types and constants for the GPR writeback path.
package wb_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned WB_WORD_SIZE = 32;

  // One buffered register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [WB_WORD_SIZE-1:0] data;
  } wb_entry_t;

  // One-hot busy mask for a destination register; x0 is never busy.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = NUM_REGS'(1) << rd;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Producer handshakes, register-file write port and status of the writeback unit.
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface writeback_unit_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned DEPTH     = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [4:0]           alu_rd;
  logic [WORD_SIZE-1:0] alu_data;

  logic                 mem_valid;
  logic                 mem_ready;
  logic [4:0]           mem_rd;
  logic [WORD_SIZE-1:0] mem_data;

  logic                 rf_write_enable;
  logic [4:0]           rf_write_addr;
  logic [WORD_SIZE-1:0] rf_write_data;

  logic [31:0]          pending_busy;
  logic [CNT_W-1:0]     fifo_count;

`ifdef WB_FORWARD_EN
  logic [4:0]           fwd_addr;
  logic                 fwd_hit;
  logic [WORD_SIZE-1:0] fwd_data;
`endif

  // Result producers / decode side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rf_write_enable, rf_write_addr, rf_write_data,
    input  pending_busy, fifo_count
`ifdef WB_FORWARD_EN
    , output fwd_addr
    , input  fwd_hit, fwd_data
`endif
  );

  // Writeback unit side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rf_write_enable, rf_write_addr, rf_write_data,
    output pending_busy, fifo_count
`ifdef WB_FORWARD_EN
    , input  fwd_addr
    , output fwd_hit, fwd_data
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes; entries are exposed for scans.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] rd_ptr,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  // Pointer, occupancy and storage update; pointers wrap modulo DEPTH.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_entry;
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU/load results into an in-order FIFO and drains one
// write per cycle to the GPR file; exports a busy-register scoreboard.
// Optional feature macro: WB_FORWARD_EN (adds fwd_addr/fwd_hit/fwd_data lookup).
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WB_WORD_SIZE,
  parameter int unsigned DEPTH     = 4
) (
  input logic             clock,
  input logic             reset_n,
  writeback_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             mem_acc;
  logic             alu_acc;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [WORD_SIZE-1:0]  wb_data;
  logic [NUM_REGS-1:0]   busy;

  // Load path has fixed priority; readiness ignores a same-cycle pop.
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;
  assign mem_acc       = bus.mem_valid && !full;
  assign alu_acc       = bus.alu_valid && !full && !bus.mem_valid;

  // Select the accepted result; writes to x0 complete the handshake but are dropped.
  always_comb begin
    push_entry = '0;
    push       = 1'b0;
    if (mem_acc) begin
      push_entry.rd   = bus.mem_rd;
      push_entry.data = WB_WORD_SIZE'(bus.mem_data);
      push            = (bus.mem_rd != '0);
    end else if (alu_acc) begin
      push_entry.rd   = bus.alu_rd;
      push_entry.data = WB_WORD_SIZE'(bus.alu_data);
      push            = (bus.alu_rd != '0);
    end
  end

  assign pop = !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .rd_ptr     (rd_ptr),
    .entries    (entries),
    .valid      (valid)
  );

  // Output stage: head moves to the register-file port; address/data hold when idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (!empty) begin
      wb_en   <= 1'b1;
      wb_addr <= head.rd;
      wb_data <= WORD_SIZE'(head.data);
    end else begin
      wb_en   <= 1'b0;
    end
  end

  assign bus.rf_write_enable = wb_en;
  assign bus.rf_write_addr   = wb_addr;
  assign bus.rf_write_data   = wb_data;
  assign bus.fifo_count      = count;

  // Scoreboard: every destination still queued or on the write port.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) busy = busy | rd_onehot(entries[i].rd);
    end
    if (wb_en) busy = busy | rd_onehot(wb_addr);
  end

  assign bus.pending_busy = busy;

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Forwarding: output stage is oldest, then FIFO oldest-to-youngest so the youngest wins.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    fwd_idx      = '0;
    if (bus.fwd_addr != '0) begin
      if (wb_en && (wb_addr == bus.fwd_addr)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = wb_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr + PTR_W'(i);
        if ((CNT_W'(i) < count) && (entries[fwd_idx].rd == bus.fwd_addr)) begin
          bus.fwd_hit  = 1'b1;
          bus.fwd_data = WORD_SIZE'(entries[fwd_idx].data);
        end
      end
    end
  end
`endif

endmodule
